change_dispenser: RTL

//  Pays out change coins after a sale: accepts an overpayment amount (Rs) via valid/ready,

---
 rtl/change_dispenser_if.sv | 26 ++
 rtl/change_dispenser.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - Change request, coin hopper and tube inventory signal bundle
interface change_dispenser_if #(
  parameter int AMT_W = 5
);
  logic             chg_valid;
  logic [AMT_W-1:0] chg_amount;
  logic             chg_ready;
  logic [3:0]       eject;
  logic             eject_done;
  logic             refill;
  logic [1:0]       refill_sel;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;
  logic [3:0]       tube_empty;

  modport master (
    output chg_valid, chg_amount, eject_done, refill, refill_sel,
    input  chg_ready, eject, done, short, remaining, tube_empty
  );

  modport slave (
    input  chg_valid, chg_amount, eject_done, refill, refill_sel,
    output chg_ready, eject, done, short, remaining, tube_empty
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - Greedy coin change payout (Rs10/5/2/1) with hopper ack and tube inventory
module change_dispenser #(
  parameter int AMT_W       = 5,
  parameter int CNT_W       = 6,
  parameter int INIT_COUNT  = 20,
  parameter int PULSE_CYC   = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  localparam int PC_W = $clog2(PULSE_CYC + 1);
  localparam int TM_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PC_W-1:0]  PULSE_LAST = PC_W'(PULSE_CYC - 1);
  localparam logic [TM_W-1:0]  TIMER_LAST = TM_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(INIT_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE} state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] rem;
  logic [1:0]       coin;
  logic [PC_W-1:0]  pulse_cnt;
  logic [TM_W-1:0]  timer;
  logic [CNT_W-1:0] count [4];
  logic             short_q;
  logic [AMT_W-1:0] remaining_q;
  logic [3:0]       empty_q;
  logic [1:0]       pick;
  logic             pick_found;
  logic             chg_ready_c;
  logic [3:0]       eject_c;
  logic             done_c;

  function automatic logic [AMT_W-1:0] coin_val(input logic [1:0] d);
    case (d)
      2'd3:    coin_val = AMT_W'(10);
      2'd2:    coin_val = AMT_W'(5);
      2'd1:    coin_val = AMT_W'(2);
      default: coin_val = AMT_W'(1);
    endcase
  endfunction

  // Ascending scan, so the last hit is the largest usable denomination.
  always_comb begin
    pick       = 2'd0;
    pick_found = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (coin_val(2'(d)) <= rem && count[d] != '0) begin
        pick       = 2'(d);
        pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    chg_ready_c = 1'b0;
    eject_c     = 4'b0000;
    done_c      = 1'b0;
    case (state)
      IDLE: begin
        chg_ready_c = 1'b1;
        if (bus.chg_valid) state_nxt = SELECT;
      end
      SELECT: begin
        state_nxt = (rem != '0 && pick_found) ? EJECT : DONE;
      end
      EJECT: begin
        eject_c = 4'b0001 << coin;
        if (pulse_cnt == PULSE_LAST) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack arriving on the timeout cycle still counts as a paid coin.
        if (bus.eject_done)            state_nxt = SELECT;
        else if (timer == TIMER_LAST)  state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem         <= '0;
      coin        <= 2'd0;
      pulse_cnt   <= '0;
      timer       <= '0;
      short_q     <= 1'b0;
      remaining_q <= '0;
      for (int d = 0; d < 4; d++) begin
        count[d]   <= CNT_INIT;
        empty_q[d] <= (CNT_INIT == '0);
      end
    end else begin
      for (int d = 0; d < 4; d++) empty_q[d] <= (count[d] == '0);
      case (state)
        IDLE: begin
          if (bus.refill && count[bus.refill_sel] != CNT_MAX)
            count[bus.refill_sel] <= count[bus.refill_sel] + CNT_W'(1);
          if (bus.chg_valid) begin
            rem         <= bus.chg_amount;
            short_q     <= 1'b0;
            remaining_q <= '0;
          end
        end
        SELECT: begin
          coin      <= pick;
          pulse_cnt <= '0;
          if (rem != '0 && !pick_found) begin
            short_q     <= 1'b1;
            remaining_q <= rem;
          end
        end
        EJECT: begin
          pulse_cnt <= pulse_cnt + PC_W'(1);
          timer     <= '0;
        end
        WAIT_ACK: begin
          timer <= timer + TM_W'(1);
          if (bus.eject_done) begin
            rem         <= rem - coin_val(coin);
            count[coin] <= count[coin] - CNT_W'(1);
          end else if (timer == TIMER_LAST) begin
            short_q     <= 1'b1;
            remaining_q <= rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.chg_ready  = chg_ready_c;
  assign bus.eject      = eject_c;
  assign bus.done       = done_c;
  assign bus.short      = short_q;
  assign bus.remaining  = remaining_q;
  assign bus.tube_empty = empty_q;

endmodule
